// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch buffer: grant-gated fetch, DEPTH-entry {pc, inst} FIFO, redirect flush.
// Optional macro PREFETCH_BYPASS_EN forwards a response straight to the outputs when the FIFO is empty.
module inst_prefetch_buffer #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     redirect_valid,
   input  logic [31:0]              redirect_pc,
   input  logic                     mem_grant,
   output logic                     mem_req,
   output logic [31:0]              mem_addr,
   input  logic [31:0]              mem_rdata,
   input  logic                     ifid_ready,
   output logic                     inst_valid,
   output logic [31:0]              inst,
   output logic [31:0]              inst_pc,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [31:0] Nop  = 32'h0000_0033;

   typedef enum logic [0:0] {StRun, StKill} state_e;

   state_e              state_q, state_d;
   logic [31:0]         fetch_pc_q, fetch_pc_d;
   logic [31:0]         resp_pc_q, resp_pc_d;
   logic                inflight_q, inflight_d;
   logic [CntW-1:0]     count_q, count_d;
   logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [31:0]         fifo_inst [DEPTH];
   logic [31:0]         fifo_pc   [DEPTH];
   logic [CntW:0]       credit;
   logic                accept, resp_valid, push, pop, bypass, empty;

   // Queued plus in-flight words never exceed DEPTH, so a push always has room.
   always_comb begin
      credit     = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
      mem_req    = !reset && !redirect_valid && (credit < (CntW + 1)'(DEPTH));
      accept     = mem_req && mem_grant;
      mem_addr   = fetch_pc_q;
      empty      = (count_q == '0);
      resp_valid = inflight_q && (state_q == StRun);
`ifdef PREFETCH_BYPASS_EN
      bypass     = empty && resp_valid && !redirect_valid;
`else
      bypass     = 1'b0;
`endif
      push       = resp_valid && !redirect_valid && !(bypass && ifid_ready);
      pop        = !empty && ifid_ready && !redirect_valid;
   end

   always_comb begin
      inst_valid = 1'b0;
      inst       = Nop;
      inst_pc    = 32'h0;
      if (!empty) begin
         inst_valid = 1'b1;
         inst       = fifo_inst[rd_ptr_q];
         inst_pc    = fifo_pc[rd_ptr_q];
      end else if (bypass) begin
         inst_valid = 1'b1;
         inst       = mem_rdata;
         inst_pc    = resp_pc_q;
      end
   end

   assign fifo_count = count_q;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      inflight_d = accept;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         if (state_q == StRun && inflight_q) state_d = StKill;
      end else begin
         if (state_q == StKill) state_d = StRun;
         if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            resp_pc_d  = fetch_pc_q;
         end
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CntW'(push) - CntW'(pop);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StRun;
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= 32'h0;
         inflight_q <= 1'b0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_inst[wr_ptr_q] <= mem_rdata;
         fifo_pc[wr_ptr_q]   <= resp_pc_q;
      end
   end

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Bench for inst_prefetch_buffer: queue-based reference model checked every cycle plus
// hand-computed literal expectations for reset, saturation, redirect, grant gaps, wrap and async reset.
module tb_inst_prefetch_buffer;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0000_0033;
`ifdef PREFETCH_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        mem_grant = 1'b0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata = 32'h0;
   logic        ifid_ready = 1'b0;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [$clog2(DEPTH):0] fifo_count;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   inst_prefetch_buffer #(
      .DEPTH    (DEPTH),
      .RESET_PC (32'h0)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .mem_grant      (mem_grant),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_rdata      (mem_rdata),
      .ifid_ready     (ifid_ready),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .fifo_count     (fifo_count)
   );

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // Memory: data for an accepted address appears the next cycle; garbage otherwise.
   always @(posedge clk) mem_rdata <= (mem_req && mem_grant) ? word_at(mem_addr) : 32'hDEAD_BEEF;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: queue of PCs, one optional word in flight, next fetch address.
   logic [31:0] m_q[$];
   logic [31:0] m_fetch_pc = 32'h0;
   logic [31:0] m_infl_pc  = 32'h0;
   bit          m_infl     = 1'b0;

   function automatic bit m_bypass();
`ifdef PREFETCH_BYPASS_EN
      return (m_q.size() == 0) && m_infl && !redirect_valid;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit m_req();
      return !redirect_valid && ((m_q.size() + int'(m_infl)) < int'(DEPTH));
   endfunction

   initial begin
      bit req, byp;
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_q.delete();
            m_fetch_pc = 32'h0;
            m_infl     = 1'b0;
         end else if (redirect_valid) begin
            m_q.delete();
            m_fetch_pc = {redirect_pc[31:2], 2'b00};
            m_infl     = 1'b0;
         end else begin
            req = m_req();
            byp = m_bypass();
            if (m_q.size() != 0 && ifid_ready) void'(m_q.pop_front());
            if (m_infl && !(byp && ifid_ready)) m_q.push_back(m_infl_pc);
            if (req && mem_grant) begin
               m_infl     = 1'b1;
               m_infl_pc  = m_fetch_pc;
               m_fetch_pc = m_fetch_pc + 32'd4;
            end else begin
               m_infl = 1'b0;
            end
         end
      end
   end

   logic [31:0] e_pc;
   bit          e_valid;
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            e_valid = 1'b0;
            e_pc    = 32'h0;
            if (m_q.size() != 0) begin
               e_valid = 1'b1;
               e_pc    = m_q[0];
            end else if (m_bypass()) begin
               e_valid = 1'b1;
               e_pc    = m_infl_pc;
            end
            check("inst_valid", 32'(inst_valid), 32'(e_valid));
            check("inst_pc", inst_pc, e_pc);
            check("inst", inst, e_valid ? word_at(e_pc) : NOP);
            check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
            check("mem_req", 32'(mem_req), 32'(m_req()));
            check("mem_addr", mem_addr, m_fetch_pc);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(2);
      reset = 1'b0;
   endtask

   initial begin
      // 1: streaming from reset
      mem_grant  = 1'b1;
      ifid_ready = 1'b1;
      do_reset();
      check("t1_reset_count", 32'(fifo_count), 32'h0);
      check("t1_reset_inst", inst, NOP);
      step(1);
      check("t1_first_valid", 32'(inst_valid), (LAT == 1) ? 32'h1 : 32'h0);
      step(1);
      check("t1_pc_e2", inst_pc, 32'(4 * (2 - LAT)));
      step(3);
      check("t1_pc_e5", inst_pc, 32'(4 * (5 - LAT)));
      step(6);

      // 2: stall saturates the FIFO, then drain
      ifid_ready = 1'b0;
      do_reset();
      step(10);
      check("t2_sat_count", 32'(fifo_count), 32'h4);
      check("t2_sat_req", 32'(mem_req), 32'h0);
      check("t2_head_pc", inst_pc, 32'h0);
      check("t2_addr", mem_addr, 32'h10);
      ifid_ready = 1'b1;
      step(1);
      check("t2_drain_pc", inst_pc, 32'h4);
      step(8);

      // 3: redirect with 3 queued and one in flight
      ifid_ready = 1'b0;
      do_reset();
      step(4);
      check("t3_pre_count", 32'(fifo_count), 32'h3);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h103;
      step(1);
      redirect_valid = 1'b0;
      check("t3_flush_count", 32'(fifo_count), 32'h0);
      check("t3_flush_addr", mem_addr, 32'h100);
      check("t3_flush_valid", 32'(inst_valid), 32'h0);
      ifid_ready = 1'b1;
      step(LAT);
      check("t3_new_pc", inst_pc, 32'h100);
      step(6);

      // 4: alternating grant
      mem_grant = 1'b1;
      do_reset();
      step(1);
      mem_grant = 1'b0;
      step(1);
      check("t4_hold_addr_a", mem_addr, 32'h4);
      mem_grant = 1'b1;
      step(1);
      mem_grant = 1'b0;
      step(1);
      check("t4_hold_addr_b", mem_addr, 32'h8);
      for (int i = 0; i < 8; i++) begin
         mem_grant = i[0];
         step(1);
      end

      // 5: address wrap at 2^32
      ifid_ready     = 1'b0;
      mem_grant      = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFE;
      step(1);
      redirect_valid = 1'b0;
      check("t5_addr_top", mem_addr, 32'hFFFF_FFFC);
      mem_grant = 1'b1;
      step(1);
      check("t5_addr_wrap", mem_addr, 32'h0);
      step(2);
      check("t5_head_top", inst_pc, 32'hFFFF_FFFC);
      ifid_ready = 1'b1;
      step(1);
      check("t5_head_wrap", inst_pc, 32'h0);
      step(4);

      // 6: asynchronous reset mid-stream
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("t6_valid", 32'(inst_valid), 32'h0);
      check("t6_inst", inst, NOP);
      check("t6_pc", inst_pc, 32'h0);
      check("t6_count", 32'(fifo_count), 32'h0);
      check("t6_req", 32'(mem_req), 32'h0);
      step(2);
      reset = 1'b0;
      check("t6_restart_addr", mem_addr, 32'h0);
      step(LAT);
      check("t6_restart_valid", 32'(inst_valid), 32'h1);
      check("t6_restart_pc", inst_pc, 32'h0);
      step(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
